vga_frame_reader: RTL and testbench

- Source side of the pixel path feeding the VGA colorizer stage.
- Generates 640x480@60 timing from a divided pixel tick, emits current x/y coordinates and sync pulses.
- Generates the image-RAM read address for a 400x400 on-screen window that shows a 100x100 image upscaled by 4. The on-screen window itself is 400x400.
- Delays coordinates and syncs by the RAM read latency so that they arrive aligned with the returned pixel data.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_sync_counter.sv | 75 +++++++
 rtl/vga_frame_reader.sv | 199 +++++++++++++++++++
 tb/tb_vga_frame_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA source path.
// Holds the default 640x480@60 timing, the default image window geometry,
// the streaming state type and the per-pixel record carried by the delay line.
package vga_pkg;

  localparam int unsigned VGA_PIX_DIV  = 2;

  localparam int unsigned VGA_H_VIS    = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_VIS    = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_WIN_X0   = 120;
  localparam int unsigned VGA_WIN_Y0   = 40;
  localparam int unsigned VGA_IMG_W    = 100;
  localparam int unsigned VGA_IMG_H    = 100;
  localparam int unsigned VGA_SCALE    = 4;
  localparam int unsigned VGA_ADDR_W   = 14;
  localparam int unsigned VGA_READ_LAT = 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       in_window;
  } pix_info_t;

  localparam pix_info_t PIX_INFO_RST = '{
    x:         '0,
    y:         '0,
    hsync:     1'b1,
    vsync:     1'b1,
    video_on:  1'b0,
    in_window: 1'b0
  };

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider plus raw horizontal/vertical position counters.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   pix_tick     one-clk pulse per pixel (divider at its last count)
//   h, v         raw position, advanced on pix_tick, always running
//   hsync, vsync raw active-low sync pulses
//   video_on     raw visible-area flag
//   frame_last   raw position is the last pixel of the frame
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV = VGA_PIX_DIV,
  parameter int unsigned H_VIS   = VGA_H_VIS,
  parameter int unsigned H_FP    = VGA_H_FP,
  parameter int unsigned H_SYNC  = VGA_H_SYNC,
  parameter int unsigned H_BP    = VGA_H_BP,
  parameter int unsigned V_VIS   = VGA_V_VIS,
  parameter int unsigned V_FP    = VGA_V_FP,
  parameter int unsigned V_SYNC  = VGA_V_SYNC,
  parameter int unsigned V_BP    = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_last
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      if (pix_tick) begin
        div <= '0;
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign pix_tick   = (div == DIV_LAST);
  assign hsync      = !((h >= HS_FIRST) && (h <= HS_LAST));
  assign vsync      = !((v >= VS_FIRST) && (v <= VS_LAST));
  assign video_on   = (h < H_VIS_C) && (v < V_VIS_C);
  assign frame_last = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA timing source and image-RAM reader for an upscaled on-screen window.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   start       streaming enable, acted on only at the frame boundary
//   ram_addr    image RAM read address (holds outside the window)
//   ram_rd_en   read strobe, one clk per pixel tick inside the window
//   x, y        column/row aligned with returned RAM data
//   hsync/vsync aligned active-low syncs
//   video_on    aligned visible-area flag
//   in_window   aligned flag: RAM data is valid for this pixel
//   pix_tick    one-clk pulse per pixel
//   frame_done  one-clk pulse on the last pixel of a streamed frame
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = VGA_PIX_DIV,
  parameter int unsigned H_VIS    = VGA_H_VIS,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_VIS    = VGA_V_VIS,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned WIN_X0   = VGA_WIN_X0,
  parameter int unsigned WIN_Y0   = VGA_WIN_Y0,
  parameter int unsigned IMG_W    = VGA_IMG_W,
  parameter int unsigned IMG_H    = VGA_IMG_H,
  parameter int unsigned SCALE    = VGA_SCALE,
  parameter int unsigned ADDR_W   = VGA_ADDR_W,
  parameter int unsigned READ_LAT = VGA_READ_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              in_window,
  output logic              pix_tick,
  output logic              frame_done
);

  localparam int unsigned SUB_W      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned LAST_STAGE = READ_LAT - 1;

  localparam logic [9:0] WX_FIRST = 10'(WIN_X0);
  localparam logic [9:0] WX_LAST  = 10'(WIN_X0 + IMG_W * SCALE - 1);
  localparam logic [9:0] WX_PRE   = 10'(WIN_X0 - 1);
  localparam logic [9:0] WY_FIRST = 10'(WIN_Y0);
  localparam logic [9:0] WY_LAST  = 10'(WIN_Y0 + IMG_H * SCALE - 1);

  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [9:0] h;
  logic [9:0] v;
  logic       hs_raw;
  logic       vs_raw;
  logic       vo_raw;
  logic       frame_last;

  vga_sync_counter #(
    .PIX_DIV (PIX_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .h          (h),
    .v          (v),
    .hsync      (hs_raw),
    .vsync      (vs_raw),
    .video_on   (vo_raw),
    .frame_last (frame_last)
  );

  // Streaming FSM: state only changes on the last pixel of a frame.
  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_tick && frame_last && start) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (pix_tick && frame_last) begin
          frame_done = 1'b1;
          if (!start) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic win_raw;
  logic win_eff;

  assign win_raw = (h >= WX_FIRST) && (h <= WX_LAST) &&
                   (v >= WY_FIRST) && (v <= WY_LAST);
  assign win_eff = win_raw && (state_q == ACTIVE);

  // Multiplier-free address walk: col_sub/row_sub count replicated pixels
  // and lines; row_base is the image-row start address for the current line.
  logic [SUB_W-1:0]  col_sub;
  logic [SUB_W-1:0]  row_sub;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_sub   <= '0;
      row_sub   <= '0;
      row_base  <= '0;
      addr      <= '0;
      last_addr <= '0;
    end else if (pix_tick) begin
      if (frame_last) begin
        row_base <= '0;
        row_sub  <= '0;
      end else if (win_eff && (h == WX_LAST)) begin
        if (row_sub == SUB_LAST) begin
          row_sub  <= '0;
          row_base <= row_base + ROW_STEP;
        end else begin
          row_sub <= row_sub + SUB_W'(1);
        end
      end

      if (h == WX_PRE) begin
        addr    <= row_base;
        col_sub <= '0;
      end else if (win_eff) begin
        last_addr <= addr;
        if (col_sub == SUB_LAST) begin
          col_sub <= '0;
          addr    <= addr + ADDR_W'(1);
        end else begin
          col_sub <= col_sub + SUB_W'(1);
        end
      end
    end
  end

  // The live address is driven combinationally so the RAM samples it on the
  // same tick edge that pushes the matching coordinates into the delay line;
  // last_addr supplies the held value once the window is left.
  assign ram_rd_en = pix_tick && win_eff;
  assign ram_addr  = win_eff ? addr : last_addr;

  pix_info_t raw_info;
  pix_info_t dly [READ_LAT];

  assign raw_info = '{
    x:         h,
    y:         v,
    hsync:     hs_raw,
    vsync:     vs_raw,
    video_on:  vo_raw,
    in_window: win_eff
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) dly[i] <= PIX_INFO_RST;
    end else if (pix_tick) begin
      dly[0] <= raw_info;
      for (int unsigned i = 1; i < READ_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign x         = dly[LAST_STAGE].x;
  assign y         = dly[LAST_STAGE].y;
  assign hsync     = dly[LAST_STAGE].hsync;
  assign vsync     = dly[LAST_STAGE].vsync;
  assign video_on  = dly[LAST_STAGE].video_on;
  assign in_window = dly[LAST_STAGE].in_window;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader using a reduced timing set so that
// many whole frames fit in a short run. The reference model tracks the pixel
// position as a single frame index and derives everything from it arithmetically.
module tb_vga_frame_reader;

  localparam int unsigned PIX_DIV  = 2;
  localparam int unsigned H_VIS    = 32;
  localparam int unsigned H_FP     = 4;
  localparam int unsigned H_SYNC   = 6;
  localparam int unsigned H_BP     = 6;
  localparam int unsigned V_VIS    = 20;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam int unsigned WIN_X0   = 6;
  localparam int unsigned WIN_Y0   = 4;
  localparam int unsigned IMG_W    = 5;
  localparam int unsigned IMG_H    = 3;
  localparam int unsigned SCALE    = 4;
  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned READ_LAT = 1;

  localparam int unsigned HT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned NPIX = HT * VT;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              hsync;
  logic              vsync;
  logic              video_on;
  logic              in_window;
  logic              pix_tick;
  logic              frame_done;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .PIX_DIV  (PIX_DIV),
    .H_VIS    (H_VIS),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_VIS    (V_VIS),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .WIN_X0   (WIN_X0),
    .WIN_Y0   (WIN_Y0),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .SCALE    (SCALE),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ram_addr   (ram_addr),
    .ram_rd_en  (ram_rd_en),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .in_window  (in_window),
    .pix_tick   (pix_tick),
    .frame_done (frame_done)
  );

  // Image RAM stand-in with one pixel-tick latency: returns the address as data.
  logic [ADDR_W-1:0] ram_data = '0;
  always @(posedge clk) if (ram_rd_en) ram_data <= ram_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit in_win(input int unsigned h, input int unsigned v);
    return h >= WIN_X0 && h < WIN_X0 + IMG_W * SCALE &&
           v >= WIN_Y0 && v < WIN_Y0 + IMG_H * SCALE;
  endfunction

  function automatic int unsigned addr_of(input int unsigned h, input int unsigned v);
    return ((v - WIN_Y0) / SCALE) * IMG_W + (h - WIN_X0) / SCALE;
  endfunction

  // Reference model state, valid just after each rising edge.
  int unsigned m_div, m_pos, m_hold;
  bit          m_active;
  int unsigned a_x, a_y;
  bit          a_hs, a_vs, a_vo, a_win;

  task automatic step();
    bit          tick, w, e_tick, cur_win;
    int unsigned h, v, e_addr;
    @(posedge clk);
    if (reset) begin
      m_div = 0; m_pos = 0; m_hold = 0; m_active = 0;
      a_x = 0; a_y = 0; a_hs = 1; a_vs = 1; a_vo = 0; a_win = 0;
    end else begin
      tick  = (m_div == PIX_DIV - 1);
      m_div = tick ? 0 : m_div + 1;
      if (tick) begin
        h = m_pos % HT;
        v = m_pos / HT;
        w = in_win(h, v) && m_active;
        a_x   = h;
        a_y   = v;
        a_hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        a_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        a_vo  = (h < H_VIS) && (v < V_VIS);
        a_win = w;
        if (w) m_hold = addr_of(h, v);
        if (m_pos == NPIX - 1) m_active = start;
        m_pos = (m_pos + 1) % NPIX;
      end
    end
    @(negedge clk);
    h       = m_pos % HT;
    v       = m_pos / HT;
    e_tick  = (m_div == PIX_DIV - 1);
    cur_win = in_win(h, v) && m_active;
    e_addr  = cur_win ? addr_of(h, v) : m_hold;
    check_eq("pix_tick",   32'(pix_tick),   32'(e_tick));
    check_eq("ram_rd_en",  32'(ram_rd_en),  32'(e_tick && cur_win));
    check_eq("ram_addr",   32'(ram_addr),   e_addr);
    check_eq("frame_done", 32'(frame_done), 32'(e_tick && m_active && m_pos == NPIX - 1));
    check_eq("x",          32'(x),          a_x);
    check_eq("y",          32'(y),          a_y);
    check_eq("hsync",      32'(hsync),      32'(a_hs));
    check_eq("vsync",      32'(vsync),      32'(a_vs));
    check_eq("video_on",   32'(video_on),   32'(a_vo));
    check_eq("in_window",  32'(in_window),  32'(a_win));
    if (a_win) check_eq("ram_data_align", 32'(ram_data), addr_of(a_x, a_y));
  endtask

  task automatic run(input int unsigned n, input logic s);
    start = s;
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (4) step();
    reset = 1'b0;

    // Idle frames: timing runs, no reads.
    run(3000, 1'b0);

    // Enable at a random point, stream for a couple of frames.
    run($urandom_range(0, 2000), 1'b0);
    run(6000, 1'b1);

    // Drop start mid-frame: current frame completes, following frame idle.
    run($urandom_range(500, 2000), 1'b1);
    run(3000, 1'b0);

    // Mid-frame reset while streaming, then streaming resumes after a boundary.
    run(4000, 1'b1);
    run($urandom_range(0, 1000), 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(6000, 1'b1);

    // Random start toggles and occasional resets.
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 399) == 0) start = ~start;
      reset = ($urandom_range(0, 2999) == 0);
      step();
    end
    reset = 1'b0;
    run(100, start);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
